e_calc_seq: RTL and testbench
=============================

Name: e_calc_seq

Overview:
Run controller for the e_calc datapath (WORDS x 16-bit result, start/done interface). It accepts a host run request, issues a single-cycle start to e_calc, and supervises completion with a timeout. It latches the wide result and streams it out one 16-bit word per valid/ready handshake, most-significant word first. It sits between e_calc and a serial consumer such as a UART or display formatter.

Parameters:
WORDS, 32, number of 16-bit result words; must match e_calc.
TIMEOUT_CYCLES, 2**24, WAIT cycles allowed before a run is declared failed; >= 2.
TMR_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  host run request, level-sampled
abort  in  1  cancel the current run
busy  out  1  high in every state except IDLE
calc_start  out  1  start pulse to e_calc
calc_done  in  1  done from e_calc
calc_data  in  16*WORDS  result vector from e_calc
word_valid  out  1  stream word valid
word_ready  in  1  stream consumer ready
word_data  out  16  current word
word_idx  out  $clog2(WORDS)  index of current word
word_last  out  1  high with word_idx==0
run_done  out  1  one-cycle pulse after the last word transfers
timeout_err  out  1  sticky timeout flag

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. All outputs are registered and reset to 0. State resets to IDLE, timer to 0, result buffer to 0.
- IDLE: if req=1 and abort=0, go to START; timeout_err clears on the same edge.
- START: calc_start=1 for exactly one cycle (the cycle after req is sampled). Timer clears. Go to WAIT.
- WAIT: timer increments every cycle.
  - calc_done=1: latch calc_data into the buffer, set word_idx=WORDS-1, go to STREAM. word_valid rises the next cycle.
  - Timer reaches TIMEOUT_CYCLES-1 without calc_done: set timeout_err and go to IDLE.
  - calc_done and timeout in the same cycle: calc_done wins.
- STREAM:
  - word_valid=1, word_data=buf[word_idx*16 +: 16], word_last=(word_idx==0).
  - A transfer occurs on valid&&ready. Without a transfer, word_valid, word_data and word_idx hold stable.
  - A transfer with word_idx>0 decrements word_idx; the next word is presented the following cycle, so back-to-back transfers give 1 word/cycle.
  - A transfer with word_last=1 returns to IDLE, drops word_valid, and pulses run_done the next cycle.
- abort=1 in START, WAIT or STREAM: go to IDLE on the next edge. word_valid and calc_start drop and run_done does not pulse. abort has priority over done, timeout and transfer. abort in IDLE blocks acceptance of req that cycle and has no other effect.
- req while busy is ignored; req held high after a run starts a new run on the first IDLE cycle.
- calc_done outside WAIT is ignored; the buffer is not updated.
- Reset mid-run: immediate return to IDLE with all outputs 0. e_calc is reset by the same rst_n.
- Latency: req sampled at edge n gives calc_start high in cycle n+1. calc_done sampled at edge m gives word_valid high at m+1. Total stream time is at least WORDS cycles.

Decomposition:
- Package e_calc_pkg holds:
  - WORD_W=16 and DEFAULT_WORDS=32.
  - typedef enum logic [2:0] {IDLE, START, WAIT, STREAM} seq_state_t.
- e_calc and its bench share this package.
- No sub-module; the timer, buffer and word mux stay inline.

Test Plan:
- Nominal run. Setup: WORDS=4, e_calc stub with done 10 cycles after start and data {16'd2,16'd7182,16'd8182,16'd8459}, word_ready=1. Required: exactly one calc_start; words 2, 7182, 8182, 8459 with idx 3..0; word_last only on 8459; run_done one cycle after.
- Backpressure. Setup: word_ready toggles 1,0,0,1 repeatedly. Required: word_data and word_idx hold while ready=0; no word is dropped or duplicated; same 4-word sequence.
- Timeout. Setup: TIMEOUT_CYCLES=16, stub never asserts done. Required: timeout_err=1 and busy=0 exactly 16 cycles after entering WAIT; next req clears timeout_err and pulses calc_start.
- Done at timeout. Setup: calc_done coincides with timer=TIMEOUT_CYCLES-1. Required: STREAM is entered and timeout_err stays 0.
- Abort. Setup: abort in WAIT, then abort in STREAM after word 2. Required: busy=0 next cycle, word_valid=0, no run_done, no extra calc_start; a later stray calc_done is ignored.
- Reset mid-STREAM. Setup: rst_n low asynchronously. Required: all outputs 0 immediately; a req after release runs normally.

Source files
------------

// File: rtl/e_calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e_calc_pkg                                                      |
// | Purpose  : Shared constants and types for the e_calc datapath, its run     |
// |            controller (e_calc_seq) and their benches.                      |
// | Contents : WORD_W        - width of one result word                        |
// |            DEFAULT_WORDS - default number of result words                  |
// |            seq_state_t   - run controller state encoding                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package e_calc_pkg;

  localparam int WORD_W        = 16;
  localparam int DEFAULT_WORDS = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/e_calc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e_calc_seq                                                      |
// | Purpose  : Run controller for e_calc. Accepts a host request, pulses       |
// |            calc_start, supervises completion with a timeout, latches the   |
// |            wide result and streams it out MS word first over valid/ready.  |
// | Ports    : clk, rst_n          - clock, async active-low reset             |
// |            req, abort          - host run request / cancel                 |
// |            busy                - high whenever not idle                    |
// |            calc_start          - one-cycle start pulse to e_calc           |
// |            calc_done/calc_data - completion and result from e_calc         |
// |            word_valid/ready    - stream handshake                          |
// |            word_data/idx/last  - current word, its index, last-word flag   |
// |            run_done            - one-cycle pulse after the last transfer   |
// |            timeout_err         - sticky timeout flag, cleared on next run  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module e_calc_seq
  import e_calc_pkg::*;
#(
  parameter int WORDS          = DEFAULT_WORDS,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic                       abort,
  output logic                       busy,
  output logic                       calc_start,
  input  logic                       calc_done,
  input  logic [WORD_W*WORDS-1:0]    calc_data,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [WORD_W-1:0]          word_data,
  output logic [$clog2(WORDS)-1:0]   word_idx,
  output logic                       word_last,
  output logic                       run_done,
  output logic                       timeout_err
);

  localparam int                IDX_W    = $clog2(WORDS);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  seq_state_t         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [WORD_W-1:0]  res_buf [WORDS];
  logic               load_buf;

  // Next values of the registered outputs.
  logic               busy_d, calc_start_d, word_valid_d, word_last_d;
  logic               run_done_d, timeout_err_d;
  logic [WORD_W-1:0]  word_data_d;
  logic [IDX_W-1:0]   word_idx_d;

  // Next-state and next-output logic. Every output is a register, so the
  // values are computed here from the next state and loaded on the edge.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    load_buf      = 1'b0;
    word_valid_d  = word_valid;
    word_data_d   = word_data;
    word_idx_d    = word_idx;
    word_last_d   = word_last;
    run_done_d    = 1'b0;
    timeout_err_d = timeout_err;

    case (state_q)
      IDLE: begin
        if (req && !abort) begin
          state_d       = START;
          timeout_err_d = 1'b0;
        end
      end

      START: begin
        timer_d = '0;
        state_d = abort ? IDLE : WAIT;
      end

      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (calc_done) begin
          // Done beats a coincident timeout. The first word comes straight
          // from calc_data since the buffer only updates on this same edge.
          state_d      = STREAM;
          load_buf     = 1'b1;
          word_valid_d = 1'b1;
          word_idx_d   = IDX_TOP;
          word_data_d  = calc_data[(WORDS-1)*WORD_W +: WORD_W];
          word_last_d  = (WORDS == 1);
        end else if (timer_q == TMR_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end

      STREAM: begin
        if (abort) begin
          state_d      = IDLE;
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
        end else if (word_valid && word_ready) begin
          if (word_last) begin
            state_d      = IDLE;
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
            run_done_d   = 1'b1;
          end else begin
            word_idx_d  = word_idx - 1'b1;
            word_data_d = res_buf[word_idx - 1'b1];
            word_last_d = (word_idx == IDX_ONE);
          end
        end
      end

      default: begin
        state_d      = IDLE;
        word_valid_d = 1'b0;
        word_last_d  = 1'b0;
      end
    endcase

    calc_start_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      busy        <= 1'b0;
      calc_start  <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_idx    <= '0;
      word_last   <= 1'b0;
      run_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      busy        <= busy_d;
      calc_start  <= calc_start_d;
      word_valid  <= word_valid_d;
      word_data   <= word_data_d;
      word_idx    <= word_idx_d;
      word_last   <= word_last_d;
      run_done    <= run_done_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Result buffer, word i holds calc_data[i*WORD_W +: WORD_W].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) res_buf[i] <= '0;
    end else if (load_buf) begin
      for (int i = 0; i < WORDS; i++) res_buf[i] <= calc_data[i*WORD_W +: WORD_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_e_calc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_e_calc_seq                                                   |
// | Purpose  : Self-checking bench for e_calc_seq (WORDS=4, TIMEOUT=16).       |
// |            e_calc is stood in for by directed calc_done/calc_data drive;   |
// |            expected words come from slicing the result vector.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_e_calc_seq;
  import e_calc_pkg::*;

  localparam int WORDS = 4;
  localparam int TOUT  = 16;
  localparam int IDX_W = $clog2(WORDS);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    req = 1'b0;
  logic                    abort = 1'b0;
  logic                    calc_done = 1'b0;
  logic                    word_ready = 1'b0;
  logic [WORD_W*WORDS-1:0] calc_data = '0;
  logic                    busy, calc_start, word_valid, word_last, run_done, timeout_err;
  logic [WORD_W-1:0]       word_data;
  logic [IDX_W-1:0]        word_idx;

  int    n_checks  = 0;
  int    n_fail    = 0;
  int    cnt_start = 0;
  int    cnt_rdone = 0;
  string step      = "reset";

  e_calc_seq #(
    .WORDS          (WORDS),
    .TIMEOUT_CYCLES (TOUT),
    .TMR_W          ($clog2(TOUT))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .abort       (abort),
    .busy        (busy),
    .calc_start  (calc_start),
    .calc_done   (calc_done),
    .calc_data   (calc_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_idx    (word_idx),
    .word_last   (word_last),
    .run_done    (run_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (calc_start) cnt_start++;
    if (run_done)   cnt_rdone++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL [%s] %s: observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, calc_start, word_valid, word_last, run_done, timeout_err,
              word_idx, word_data}, 64'd0);
  endtask

  // Request a run; returns in the cycle where calc_start should be high.
  task automatic start_run(input bit keep_req);
    req = 1'b1;
    tick;
    if (!keep_req) req = 1'b0;
    chk("calc_start", calc_start, 1);
    chk("busy_start", busy, 1);
    chk("terr_cleared", timeout_err, 0);
  endtask

  // Enter WAIT, let k cycles pass, then present calc_done with timer == k.
  task automatic wait_done(input int k, input logic [63:0] data);
    tick;
    chk("start_one_cycle", calc_start, 0);
    repeat (k) tick;
    calc_done = 1'b1;
    calc_data = data;
    tick;
    calc_done = 1'b0;
    chk("valid_after_done", word_valid, 1);
    chk("busy_stream", busy, 1);
    chk("terr_stream", timeout_err, 0);
  endtask

  // Consume n_xfer words; mode 0: ready=1, 1: ready 1,0,0,1..., else random.
  task automatic stream(input logic [63:0] data, input int mode, input int n_xfer);
    logic [WORD_W-1:0] exp_q[$];
    int cyc;
    int xfers;
    cyc   = 0;
    xfers = 0;
    for (int i = WORDS - 1; i >= 0; i--) exp_q.push_back(data[i*WORD_W +: WORD_W]);
    while (xfers < n_xfer && cyc < 64) begin
      case (mode)
        0:       word_ready = 1'b1;
        1:       word_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
      chk("word_valid", word_valid, 1);
      chk("word_data", word_data, exp_q[0]);
      chk("word_idx", word_idx, exp_q.size() - 1);
      chk("word_last", word_last, exp_q.size() == 1);
      if (word_ready) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      tick;
      cyc++;
    end
    word_ready = 1'b0;
    chk("stream_complete", xfers, n_xfer);
  endtask

  task automatic end_checks(input int starts_before, input int rdone_before);
    chk("run_done_pulse", run_done, 1);
    chk("valid_dropped", word_valid, 0);
    chk("busy_end", busy, 0);
    tick;
    chk("run_done_one_cycle", run_done, 0);
    chk("one_start_per_run", cnt_start - starts_before, 1);
    chk("one_run_done", cnt_rdone - rdone_before, 1);
  endtask

  initial begin
    logic [63:0] d;
    int s0;
    int r0;

    // Reset
    rst_n = 1'b0;
    #12;
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick;
    chk_all_zero("idle_after_reset");

    // Nominal run
    step = "nominal";
    d = {16'd2, 16'd7182, 16'd8182, 16'd8459};
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    wait_done(9, d);
    stream(d, 0, WORDS);
    end_checks(s0, r0);

    // Backpressure
    step = "backpressure";
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    wait_done(4, d);
    stream(d, 1, WORDS);
    end_checks(s0, r0);

    // Timeout: no done, flag and idle exactly TOUT cycles after entering WAIT
    step = "timeout";
    start_run(1'b0);
    tick;
    repeat (TOUT - 1) tick;
    chk("busy_before_timeout", busy, 1);
    chk("terr_before_timeout", timeout_err, 0);
    tick;
    chk("terr_set", timeout_err, 1);
    chk("busy_after_timeout", busy, 0);
    tick;
    chk("terr_sticky", timeout_err, 1);
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    d = {$urandom, $urandom};
    wait_done($urandom_range(0, TOUT - 2), d);
    stream(d, 2, WORDS);
    end_checks(s0, r0);

    // Done coincides with the last timer value
    step = "done_at_timeout";
    d = {$urandom, $urandom};
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    wait_done(TOUT - 1, d);
    stream(d, 0, WORDS);
    end_checks(s0, r0);
    chk("terr_still_clear", timeout_err, 0);

    // Abort in WAIT, then a stray done while idle
    step = "abort_wait";
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("busy_abort_wait", busy, 0);
    chk("valid_abort_wait", word_valid, 0);
    repeat (3) tick;
    calc_done = 1'b1;
    calc_data = {$urandom, $urandom};
    tick;
    calc_done = 1'b0;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_valid", word_valid, 0);
    tick;
    chk("abort_wait_starts", cnt_start - s0, 1);
    chk("abort_wait_no_run_done", cnt_rdone - r0, 0);

    // Abort in STREAM after two words; abort beats a concurrent transfer
    step = "abort_stream";
    d = {$urandom, $urandom};
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    wait_done(3, d);
    stream(d, 0, 2);
    chk("third_word", word_data, d[1*WORD_W +: WORD_W]);
    abort = 1'b1;
    word_ready = 1'b1;
    tick;
    abort = 1'b0;
    word_ready = 1'b0;
    chk("busy_abort_stream", busy, 0);
    chk("valid_abort_stream", word_valid, 0);
    chk("run_done_abort_stream", run_done, 0);
    tick;
    chk("abort_stream_starts", cnt_start - s0, 1);
    chk("abort_stream_no_run_done", cnt_rdone - r0, 0);

    // Abort in IDLE blocks req; abort in START
    step = "abort_idle";
    req = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_start", calc_start, 0);
    tick;
    req = 1'b0;
    chk("req_after_abort", calc_start, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_pulse", calc_start, 0);

    // Asynchronous reset in STREAM
    step = "reset_stream";
    d = {$urandom, $urandom};
    start_run(1'b0);
    wait_done(5, d);
    stream(d, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    #3;
    rst_n = 1'b1;
    tick;
    chk_all_zero("idle_after_release");
    d = {$urandom, $urandom};
    s0 = cnt_start; r0 = cnt_rdone;
    start_run(1'b0);
    wait_done(7, d);
    stream(d, 2, WORDS);
    end_checks(s0, r0);

    // Random runs
    for (int n = 0; n < 4; n++) begin
      step = $sformatf("random_%0d", n);
      d = {$urandom, $urandom};
      s0 = cnt_start; r0 = cnt_rdone;
      start_run(1'b0);
      wait_done($urandom_range(0, TOUT - 1), d);
      stream(d, 2, WORDS);
      end_checks(s0, r0);
    end

    // req held high: ignored while busy, restarts on first idle cycle
    step = "req_held";
    d = {$urandom, $urandom};
    s0 = cnt_start;
    start_run(1'b1);
    wait_done(2, d);
    stream(d, 0, WORDS);
    chk("held_run_done", run_done, 1);
    chk("held_busy_idle", busy, 0);
    tick;
    chk("held_restart", calc_start, 1);
    chk("held_busy_again", busy, 1);
    req = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("held_abort_idle", busy, 0);
    tick;
    chk("held_start_count", cnt_start - s0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached in step %s", step);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
